// File: rtl/gesture_weight_bank_pkg.sv
// Shared types and the analytic directional weight pattern for the gesture weight bank.
// weight_pattern is used by the init sequencer and by any reference model.
package gesture_pkg;

  typedef enum logic [1:0] {
    CLS_UP    = 2'd0,
    CLS_DOWN  = 2'd1,
    CLS_LEFT  = 2'd2,
    CLS_RIGHT = 2'd3
  } class_e;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int DEF_NUM_CLASSES = 4;
  localparam int DEF_GRID_SIZE   = 32;
  localparam int DEF_WEIGHT_BITS = 8;
  localparam int DEF_POS_STEP    = 6;
  localparam int DEF_NEG_STEP    = 4;

  // Classes beyond RIGHT have no analytic pattern and initialise to 0.
  function automatic int weight_pattern(input int cls, input int cx, input int cy,
                                        input int grid, input int pos_step,
                                        input int neg_step, input int w);
    int   centre;
    int   coord;
    int   raw;
    int   hi;
    int   lo;
    logic pos_low;
    centre  = grid / 2;
    raw     = 0;
    coord   = (cls == int'(CLS_LEFT) || cls == int'(CLS_RIGHT)) ? cx : cy;
    pos_low = (cls == int'(CLS_UP) || cls == int'(CLS_LEFT));
    if (cls >= 0 && cls <= int'(CLS_RIGHT)) begin
      if (coord < centre)
        raw = pos_low ? (centre - coord) * pos_step : -((centre - coord) * neg_step);
      else
        raw = pos_low ? -((coord - centre + 1) * neg_step) : (coord - centre + 1) * pos_step;
    end
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (raw > hi) return hi;
    if (raw < lo) return lo;
    return raw;
  endfunction

endpackage

// File: rtl/gesture_weight_bank_if.sv
// Read request/response and weight load channels of the gesture weight bank.
interface gesture_weight_bank_if #(
  parameter int NUM_CLASSES = 4,
  parameter int GRID_SIZE   = 32,
  parameter int WEIGHT_BITS = 8
);
  localparam int AW = $clog2(GRID_SIZE * GRID_SIZE);
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                               req_valid;
  logic                               req_ready;
  logic [AW-1:0]                      req_addr;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [NUM_CLASSES*WEIGHT_BITS-1:0] rsp_data;
  logic                               ld_valid;
  logic                               ld_ready;
  logic [CW-1:0]                      ld_class;
  logic [AW-1:0]                      ld_addr;
  logic [WEIGHT_BITS-1:0]             ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_valid, ld_class, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, ld_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_valid, ld_class, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, ld_ready
  );

endinterface

// File: rtl/gesture_weight_bank_ram.sv
// Single-class weight store: one write port, one synchronous read port.
// The read register holds its value when re is low so a stalled response stays stable.
module weight_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gesture_weight_bank.sv
// Multi-class runtime-loadable weight bank: init sequencer, load port and parallel read.
//  state | meaning
//  INIT  | write analytic pattern of cell init_cnt to every class
//  IDLE  | serve reads and single-weight loads
module gesture_weight_bank
  import gesture_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int GRID_SIZE   = DEF_GRID_SIZE,
  parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
  parameter int POS_STEP    = DEF_POS_STEP,
  parameter int NEG_STEP    = DEF_NEG_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  output logic                  busy,
  output logic                  init_done,
  gesture_weight_bank_if.slave  bus
);

  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int AW        = $clog2(NUM_CELLS);

  localparam logic [0:0] S_INIT = ST_INIT;
  localparam logic [0:0] S_IDLE = ST_IDLE;

  logic [0:0]    state;
  logic [AW-1:0] init_cnt;
  logic          idle;
  logic          req_fire;
  logic          ld_fire;
  logic          init_we;
  logic [AW-1:0] wr_addr;
  int            cx;
  int            cy;

  logic [NUM_CLASSES-1:0][WEIGHT_BITS-1:0] rd_all;

  assign idle          = (state == S_IDLE);
  assign busy          = !idle;
  assign bus.ld_ready  = idle;
  // A load has priority; a read is stalled (not dropped) while a load is offered.
  assign bus.req_ready = idle && !bus.ld_valid && (!bus.rsp_valid || bus.rsp_ready);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign ld_fire       = bus.ld_valid && idle;
  assign init_we       = !idle;
  assign wr_addr       = init_we ? init_cnt : bus.ld_addr;
  assign cx            = int'(init_cnt) % GRID_SIZE;
  assign cy            = int'(init_cnt) / GRID_SIZE;
  assign bus.rsp_data  = rd_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      if (state == S_INIT) begin
        if (init_cnt == AW'(NUM_CELLS - 1)) begin
          state     <= S_IDLE;
          init_cnt  <= '0;
          init_done <= 1'b1;
        end else begin
          init_cnt <= init_cnt + AW'(1);
        end
      end else if (init_start) begin
        state    <= S_INIT;
        init_cnt <= '0;
      end
    end
  end

  // A response already in flight when init starts is still allowed to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             bus.rsp_valid <= 1'b0;
    else if (req_fire)      bus.rsp_valid <= 1'b1;
    else if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
    logic [WEIGHT_BITS-1:0] init_w;
    logic [WEIGHT_BITS-1:0] wdata;
    logic                   we;

    assign init_w = WEIGHT_BITS'(weight_pattern(k, cx, cy, GRID_SIZE, POS_STEP,
                                                NEG_STEP, WEIGHT_BITS));
    assign we     = init_we || (ld_fire && (int'(bus.ld_class) == k));
    assign wdata  = init_we ? init_w : bus.ld_data;

    weight_bank_ram #(
      .DEPTH (NUM_CELLS),
      .WIDTH (WEIGHT_BITS)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wr_addr),
      .wdata (wdata),
      .re    (req_fire),
      .raddr (bus.req_addr),
      .rdata (rd_all[k])
    );
  end

endmodule

// File: tb/tb_gesture_weight_bank.sv
// Self-checking bench for gesture_weight_bank: per-cycle behavioural model plus literal checks.
`timescale 1ns/1ps
module tb_gesture_weight_bank;
  import gesture_pkg::*;

  localparam int NC    = 4;
  localparam int GS    = 32;
  localparam int W     = 8;
  localparam int NCELL = GS * GS;
  localparam int AW    = $clog2(NCELL);

  logic clk = 1'b0;
  logic rst_n;
  logic init_start;
  logic busy, init_done;
  logic init_start2;
  logic busy2, init_done2;

  always #5 clk = ~clk;

  gesture_weight_bank_if #(.NUM_CLASSES(NC), .GRID_SIZE(GS), .WEIGHT_BITS(W)) bus ();
  gesture_weight_bank_if #(.NUM_CLASSES(NC), .GRID_SIZE(GS), .WEIGHT_BITS(W)) bus2 ();

  gesture_weight_bank #(
    .NUM_CLASSES(NC), .GRID_SIZE(GS), .WEIGHT_BITS(W), .POS_STEP(6), .NEG_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .busy(busy), .init_done(init_done), .bus(bus)
  );

  gesture_weight_bank #(
    .NUM_CLASSES(NC), .GRID_SIZE(GS), .WEIGHT_BITS(W), .POS_STEP(10), .NEG_STEP(10)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .init_start(init_start2),
    .busy(busy2), .init_done(init_done2), .bus(bus2)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int wsel(input logic [NC*W-1:0] d, input int k);
    logic signed [W-1:0] v;
    v = d[k*W +: W];
    return int'(v);
  endfunction

  // Reference model: the weight table as a plain array, outputs derived from handshake rules.
  logic signed [W-1:0] mdl   [NC][NCELL];
  logic signed [W-1:0] m_rsp [NC];
  int                  m_init_left;
  bit                  m_done;
  bit                  m_rsp_valid;
  int                  rsp_hs = 0;

  function automatic void mdl_fill();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < NCELL; a++)
        mdl[c][a] = W'(weight_pattern(c, a % GS, a / GS, GS, 6, 4, W));
  endfunction

  initial begin : monitor
    bit                  exp_rr, exp_lr, rf, lf;
    logic signed [W-1:0] got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_init_left = NCELL;
        m_done      = 1'b0;
        m_rsp_valid = 1'b0;
        for (int k = 0; k < NC; k++) m_rsp[k] = '0;
        mdl_fill();
        chk("rst_busy",      int'(busy), 1);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_ld_ready",  int'(bus.ld_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.rsp_data), 0);
        continue;
      end
      exp_lr = (m_init_left == 0);
      exp_rr = exp_lr && !bus.ld_valid && (!m_rsp_valid || bus.rsp_ready);
      chk("busy",      int'(busy), int'(!exp_lr));
      chk("init_done", int'(init_done), int'(m_done));
      chk("req_ready", int'(bus.req_ready), int'(exp_rr));
      chk("ld_ready",  int'(bus.ld_ready), int'(exp_lr));
      chk("rsp_valid", int'(bus.rsp_valid), int'(m_rsp_valid));
      for (int k = 0; k < NC; k++) begin
        got = bus.rsp_data[k*W +: W];
        chk("rsp_data", int'(got), int'(m_rsp[k]));
      end
      if (bus.rsp_valid && bus.rsp_ready) rsp_hs++;
      rf = exp_rr && bus.req_valid;
      lf = exp_lr && bus.ld_valid;
      m_done = 1'b0;
      if (rf) begin
        m_rsp_valid = 1'b1;
        for (int k = 0; k < NC; k++) m_rsp[k] = mdl[k][bus.req_addr];
      end else if (bus.rsp_ready) begin
        m_rsp_valid = 1'b0;
      end
      if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0) m_done = 1'b1;
      end else begin
        if (lf && int'(bus.ld_class) < NC) mdl[bus.ld_class][bus.ld_addr] = bus.ld_data;
        if (init_start) begin
          m_init_left = NCELL;
          mdl_fill();
        end
      end
    end
  end

  bit req_acc, ld_acc, rr_s;

  task automatic step();
    @(negedge clk);
    req_acc = bus.req_valid && bus.req_ready;
    ld_acc  = bus.ld_valid && bus.ld_ready;
    rr_s    = bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  // cyc counts clock cycles with the calling cycle as 1.
  task automatic wait_idle(input string nm, input int budget, output int cyc);
    cyc = 1;
    while (!init_done && cyc < budget) begin
      step();
      cyc++;
    end
    if (!init_done) chk(nm, 0, 1);
  endtask

  task automatic do_read(input int addr, output logic [NC*W-1:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = AW'(addr);
    bus.rsp_ready = 1'b1;
    do begin
      step();
      n++;
    end while (!req_acc && n < 100);
    bus.req_valid = 1'b0;
    if (!req_acc) chk("read_accept_timeout", 0, 1);
    chk("read_rsp_valid", int'(bus.rsp_valid), 1);
    d = bus.rsp_data;
    step();
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int               cyc;
    int               n;
    int               hs0;
    logic [NC*W-1:0]  d;

    rst_n = 1'b1;
    init_start = 1'b0;
    init_start2 = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_class = '0; bus.ld_addr = '0; bus.ld_data = '0;
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.rsp_ready = 1'b0;
    bus2.ld_valid = 1'b0; bus2.ld_class = '0; bus2.ld_addr = '0; bus2.ld_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    wait_idle("init_timeout", 3000, cyc);
    chk("init_done_cycle", cyc, NCELL + 1);
    step();
    chk("init_done_one_cycle", int'(init_done), 0);
    chk("busy_after_init", int'(busy), 0);

    chk("model_up_0", int'(mdl[0][0]), 96);
    chk("model_right_16", int'(mdl[3][16]), 6);

    do_read(0, d);
    chk("a0_up", wsel(d, 0), 96);    chk("a0_down", wsel(d, 1), -64);
    chk("a0_left", wsel(d, 2), 96);  chk("a0_right", wsel(d, 3), -64);
    do_read(16, d);
    chk("a16_up", wsel(d, 0), 96);   chk("a16_down", wsel(d, 1), -64);
    chk("a16_left", wsel(d, 2), -4); chk("a16_right", wsel(d, 3), 6);
    do_read(1023, d);
    chk("a1023_up", wsel(d, 0), -64);   chk("a1023_down", wsel(d, 1), 96);
    chk("a1023_left", wsel(d, 2), -64); chk("a1023_right", wsel(d, 3), 96);

    // Saturation: steps of 10 push the corner magnitudes to 160.
    bus2.req_valid = 1'b1; bus2.req_addr = AW'(0); bus2.rsp_ready = 1'b1;
    step();
    chk("sat_rsp_valid", int'(bus2.rsp_valid), 1);
    chk("sat_up_a0", wsel(bus2.rsp_data, 0), 127);
    bus2.req_addr = AW'(1023);
    step();
    chk("sat_up_a1023", wsel(bus2.rsp_data, 0), -128);
    bus2.req_valid = 1'b0;

    // Load collides with a read to the same cell.
    bus.ld_valid = 1'b1; bus.ld_class = 2'd2; bus.ld_addr = AW'(5); bus.ld_data = 8'hF9;
    bus.req_valid = 1'b1; bus.req_addr = AW'(5); bus.rsp_ready = 1'b1;
    step();
    chk("ld_accepted", int'(ld_acc), 1);
    chk("req_blocked_by_ld", int'(rr_s), 0);
    bus.ld_valid = 1'b0;
    do_read(5, d);
    chk("ld_left", wsel(d, 2), -7);  chk("ld_up", wsel(d, 0), 96);
    chk("ld_down", wsel(d, 1), -64); chk("ld_right", wsel(d, 3), -44);

    // Back-to-back reads with random backpressure.
    hs0 = rsp_hs;
    for (int a = 0; a < 8; a++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(a);
      n = 0;
      do begin
        bus.rsp_ready = 1'($urandom % 2);
        step();
        n++;
      end while (!req_acc && n < 200);
      if (!req_acc) chk("b2b_accept_timeout", 0, 1);
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid && n < 200) begin
      bus.rsp_ready = 1'($urandom % 2);
      step();
      n++;
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("b2b_responses", rsp_hs - hs0, 8);

    // Random mix of reads, loads, backpressure and one re-init.
    req_acc = 1'b0;
    ld_acc  = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.req_valid || req_acc) begin
        bus.req_valid = 1'($urandom % 2);
        bus.req_addr  = AW'($urandom_range(0, 15));
      end
      if (!bus.ld_valid || ld_acc) begin
        bus.ld_valid = ($urandom % 4 == 0);
        bus.ld_class = 2'($urandom % NC);
        bus.ld_addr  = AW'($urandom_range(0, 15));
        bus.ld_data  = W'($urandom);
      end
      bus.rsp_ready = ($urandom % 4 != 0);
      init_start    = (i == 700);
      step();
    end
    init_start = 1'b0;
    bus.req_valid = 1'b0; bus.ld_valid = 1'b0; bus.rsp_ready = 1'b1;
    wait_idle("rand_init_timeout", 3000, cyc);
    step();

    // Pending response, re-init, then reset at init_cnt=500.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = AW'(3);
    step();
    bus.req_valid = 1'b0;
    chk("pend_rsp_valid", int'(bus.rsp_valid), 1);
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (500) step();
    chk("pend_held_in_init", int'(bus.rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_mid_busy", int'(busy), 1);
    repeat (2) step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    wait_idle("reinit_timeout", 3000, cyc);
    chk("reinit_cycle", cyc, NCELL + 1);
    step();

    // Loaded weight reverts after an init_start.
    bus.ld_valid = 1'b1; bus.ld_class = 2'd2; bus.ld_addr = AW'(5); bus.ld_data = 8'hF9;
    step();
    chk("ld2_accepted", int'(ld_acc), 1);
    bus.ld_valid = 1'b0;
    do_read(5, d);
    chk("ld2_left", wsel(d, 2), -7);
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    wait_idle("revert_timeout", 3000, cyc);
    step();
    do_read(5, d);
    chk("revert_left", wsel(d, 2), 66);
    chk("revert_up", wsel(d, 0), 96);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
